// File: rtl/rr_decode_scheduler.sv
// Round-robin owner of a shared 3-to-8 decoder: grants one of 8 requesters at a
// time, bounds each grant to HOLD_MAX cycles and inserts an idle cycle between grants.
module rr_decode_scheduler #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iReq,
    input  logic       iRelease,
    output logic [2:0] oSel,
    output logic [1:0] oEna,
    output logic [7:0] oGrant,
    output logic       oValid,
    output logic       oTimeout
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [1:0] ENA_ON    = 2'b10;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] grant_q, grant_d;
    logic [1:0] ena_q, ena_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       expire;
    logic       exit_w;

    // Circular search starting at ptr; 3-bit add gives the 7 -> 0 wrap for free.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && iReq[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign expire = (hold_q == HOLD_LAST);
    assign exit_w = iRelease | ~iReq[sel_q] | expire;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        ena_d     = ena_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    grant_d = 8'b1 << pick;
                    ena_d   = ENA_ON;
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (exit_w) begin
                    // sel is left alone so the decoder input stays stable while disabled
                    grant_d   = 8'h00;
                    ena_d     = 2'b00;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 3'd1;
                    timeout_d = expire & ~iRelease & iReq[sel_q];
                    state_d   = IDLE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            hold_q    <= 8'd0;
            sel_q     <= 3'd0;
            grant_q   <= 8'h00;
            ena_q     <= 2'b00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            ena_q     <= ena_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign oSel     = sel_q;
    assign oEna     = ena_q;
    assign oGrant   = grant_q;
    assign oValid   = valid_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Bench for rr_decode_scheduler (HOLD_MAX = 4): directed scenarios plus random
// traffic, every output compared each cycle against a grant-age reference model.
module tb_rr_decode_scheduler;

    localparam int HOLD = 4;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic [7:0] iReq;
    logic       iRelease;
    logic [2:0] oSel;
    logic [1:0] oEna;
    logic [7:0] oGrant;
    logic       oValid;
    logic       oTimeout;

    int checks = 0;
    int fails  = 0;

    // Reference model: who holds the decoder, how many cycles it has held it,
    // where the next search starts, and whether the last grant expired.
    int m_on, m_who, m_age, m_ptr, m_to;

    rr_decode_scheduler #(.HOLD_MAX(HOLD)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iRelease(iRelease),
        .oSel(oSel), .oEna(oEna), .oGrant(oGrant), .oValid(oValid), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_who = 0; m_age = 0; m_ptr = 0; m_to = 0;
    endtask

    task automatic model_step();
        int rel, drop, expd;
        if (m_on == 0) begin
            m_to = 0;
            for (int i = 0; i < 8; i++) begin
                if (m_on == 0 && iReq[(m_ptr + i) % 8]) begin
                    m_on  = 1;
                    m_who = (m_ptr + i) % 8;
                    m_age = 1;
                end
            end
        end else begin
            rel  = int'(iRelease);
            drop = int'(!iReq[m_who]);
            expd = int'(m_age == HOLD);
            if (rel != 0 || drop != 0 || expd != 0) begin
                m_on  = 0;
                m_ptr = (m_who + 1) % 8;
                m_to  = (expd != 0 && rel == 0 && drop == 0) ? 1 : 0;
            end else begin
                m_age++;
                m_to = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        logic [7:0] sel8, ena8, inv_g;
        eg    = (m_on != 0) ? (8'h01 << m_who) : 8'h00;
        sel8  = {5'd0, oSel};
        ena8  = {6'd0, oEna};
        inv_g = oValid ? (8'h01 << oSel) : 8'h00;
        chk("sel", sel8, 8'(m_who));
        chk("ena", ena8, (m_on != 0) ? 8'h02 : 8'h00);
        chk("grant", oGrant, eg);
        chk("valid", {7'd0, oValid}, 8'(m_on));
        chk("timeout", {7'd0, oTimeout}, 8'(m_to));
        chk("inv_ena", ena8, oValid ? 8'h02 : 8'h00);
        chk("inv_grant", oGrant, inv_g);
        chk("inv_onehot", {7'd0, $onehot0(oGrant)}, 8'h01);
    endtask

    task automatic tick();
        @(posedge iClk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 16 && m_on != 0; n++) tick();
        chk("wait_idle", {7'd0, oValid}, 8'h00);
    endtask

    task automatic mid_reset();
        iReq = 8'hFF;
        #2;
        iRst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ena", {6'd0, oEna}, 8'h00);
        chk("rst_grant", oGrant, 8'h00);
        chk("rst_valid", {7'd0, oValid}, 8'h00);
        chk("rst_timeout", {7'd0, oTimeout}, 8'h00);
        @(negedge iClk);
        iReq   = 8'h01;
        iRst_n = 1'b1;
        tick();
        chk("post_rst_grant", oGrant, 8'h01);
        chk("post_rst_sel", {5'd0, oSel}, 8'h00);
    endtask

    initial begin
        int tos;
        iRst_n = 1'b0; iReq = 8'h00; iRelease = 1'b0;
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        check_all();
        @(negedge iClk);
        iRst_n = 1'b1;

        // Single requester with release on the 3rd grant cycle, then regrant.
        iReq = 8'h04;
        tick();
        chk("single_c1", oGrant, 8'h04);
        tick();
        tick();
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        chk("single_gap", oGrant, 8'h00);
        chk("single_to", {7'd0, oTimeout}, 8'h00);
        tick();
        chk("single_regrant", oGrant, 8'h04);

        // Full contention: every grant runs to expiry and pulses timeout.
        iReq = 8'hFF;
        wait_idle();
        tos = 0;
        for (int n = 0; n < 9 * (HOLD + 1); n++) begin
            tick();
            if (oTimeout) tos++;
        end
        chk("full_timeouts", 8'(tos), 8'd9);

        // Wrap: after a grant to 6, ptr=7, so 0 beats 6.
        iReq = 8'h40;
        for (int n = 0; n < 16 && !(m_on != 0 && m_who == 6); n++) tick();
        chk("wrap_hold6", oGrant, 8'h40);
        wait_idle();
        iReq = 8'h41;
        tick();
        chk("wrap_sel", {5'd0, oSel}, 8'h00);
        chk("wrap_grant", oGrant, 8'h01);

        // Request drop on the 2nd grant cycle; ptr then starts at 4.
        iReq = 8'h00;
        wait_idle();
        iReq = 8'h08;
        tick();
        tick();
        iReq = 8'h00;
        tick();
        chk("drop_valid", {7'd0, oValid}, 8'h00);
        chk("drop_to", {7'd0, oTimeout}, 8'h00);
        iReq = 8'h18;
        tick();
        chk("drop_ptr_sel", {5'd0, oSel}, 8'h04);

        // Release coinciding with expiry, then request drop coinciding with expiry.
        iReq = 8'h00;
        wait_idle();
        iReq = 8'h20;
        repeat (4) tick();
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        chk("simul_rel_valid", {7'd0, oValid}, 8'h00);
        chk("simul_rel_to", {7'd0, oTimeout}, 8'h00);
        repeat (4) tick();
        chk("simul_drop_held", oGrant, 8'h20);
        iReq = 8'h00;
        tick();
        chk("simul_drop_valid", {7'd0, oValid}, 8'h00);
        chk("simul_drop_to", {7'd0, oTimeout}, 8'h00);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) mid_reset();
            iReq     = 8'($urandom) & 8'($urandom) | 8'($urandom_range(0, 1) << $urandom_range(0, 7));
            iRelease = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
